// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - fetch/data arbiter for the single memory port.
// Optional MEM_ARB_RR_EN: round-robin between fetch and data instead of data-first priority.
module mem_bus_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_ok,
  output logic [31:0]         i_data,
  input  logic                d_req,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [2:0]          d_size,
  input  logic                d_write,
  input  logic [DATA_W/8-1:0] d_strobe,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_ok,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                m_valid,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [2:0]          m_size,
  output logic                m_write,
  output logic [DATA_W/8-1:0] m_strobe,
  output logic [DATA_W-1:0]   m_wdata,
  input  logic                m_ok,
  input  logic [DATA_W-1:0]   m_rdata
);

  localparam logic [2:0] MSIZE4 = 3'd2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  drop_q, drop_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [2:0]            size_q, size_d;
  logic                  write_q, write_d;
  logic [DATA_W/8-1:0]   strobe_q, strobe_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic                  fetch_wins;
  logic                  active;

`ifdef MEM_ARB_RR_EN
  logic last_d_q, last_d_d;

  // With both requesting, whoever was not served last goes next.
  always_comb begin
    fetch_wins = last_d_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      last_d_q <= 1'b0;
    end else begin
      last_d_q <= last_d_d;
    end
  end
`else
  always_comb begin
    fetch_wins = 1'b0;
  end
`endif

  always_comb begin
    state_d  = state_q;
    drop_d   = drop_q;
    addr_d   = addr_q;
    size_d   = size_q;
    write_d  = write_q;
    strobe_d = strobe_q;
    wdata_d  = wdata_q;
`ifdef MEM_ARB_RR_EN
    last_d_d = last_d_q;
`endif
    case (state_q)
      IDLE: begin
        if (d_req && !(i_req && fetch_wins)) begin
          state_d  = BUSY_D;
          addr_d   = d_addr;
          size_d   = d_size;
          write_d  = d_write;
          strobe_d = d_strobe;
          wdata_d  = d_wdata;
`ifdef MEM_ARB_RR_EN
          last_d_d = 1'b1;
`endif
        end else if (i_req) begin
          state_d  = BUSY_I;
          addr_d   = i_addr;
          size_d   = MSIZE4;
          write_d  = 1'b0;
          strobe_d = '0;
          wdata_d  = '0;
`ifdef MEM_ARB_RR_EN
          last_d_d = 1'b0;
`endif
        end
      end
      BUSY_I: begin
        // A flushed fetch still has to drain downstream; only its response is discarded.
        if (m_ok) begin
          state_d = IDLE;
          drop_d  = 1'b0;
        end else if (!i_req) begin
          drop_d = 1'b1;
        end
      end
      BUSY_D: begin
        if (m_ok) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        drop_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      drop_q   <= 1'b0;
      addr_q   <= '0;
      size_q   <= '0;
      write_q  <= 1'b0;
      strobe_q <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      drop_q   <= drop_d;
      addr_q   <= addr_d;
      size_q   <= size_d;
      write_q  <= write_d;
      strobe_q <= strobe_d;
      wdata_q  <= wdata_d;
    end
  end

  // Outputs are forced quiet while reset is low so an aborted access never completes.
  always_comb begin
    active   = reset && (state_q != IDLE);
    m_valid  = active;
    m_addr   = active ? addr_q   : '0;
    m_size   = active ? size_q   : '0;
    m_write  = active ? write_q  : 1'b0;
    m_strobe = active ? strobe_q : '0;
    m_wdata  = active ? wdata_q  : '0;
    i_ok     = reset && (state_q == BUSY_I) && m_ok && !drop_q && i_req;
    d_ok     = reset && (state_q == BUSY_D) && m_ok;
    d_rdata  = active ? m_rdata : '0;
    if (!active) begin
      i_data = 32'd0;
    end else if (addr_q[2]) begin
      i_data = m_rdata[63:32];
    end else begin
      i_data = m_rdata[31:0];
    end
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-requester arbiter that shares the core's single memory port between the fetch stage (instruction reads) and the memory stage (data loads/stores). It sits between the pipeline and the memory interface. It grants one requester at a time, holds the grant until the memory completes, and routes the response back to the granted requester. Stall generation in the pipeline is driven directly by the per-requester `*_ok` outputs.

## Interface
Parameters:
- `ADDR_W`, 64, address width.
- `DATA_W`, 64, memory data width (byte strobe width = `DATA_W/8`).

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `i_req`  in  1  fetch request; held high until `i_ok`, or dropped on flush.
- `i_addr`  in  ADDR_W  fetch address, 4-byte aligned.
- `i_ok`  out  1  fetch complete, 1-cycle pulse.
- `i_data`  out  32  fetched instruction.
- `d_req`  in  1  data request; held high until `d_ok`.
- `d_addr`  in  ADDR_W  data address.
- `d_size`  in  3  access size (`msize_t` encoding).
- `d_write`  in  1  1 = store.
- `d_strobe`  in  DATA_W/8  store byte enables.
- `d_wdata`  in  DATA_W  store data.
- `d_ok`  out  1  data access complete, 1-cycle pulse.
- `d_rdata`  out  DATA_W  load data.
- `m_valid`  out  1  downstream request valid.
- `m_addr`, `m_size`, `m_write`, `m_strobe`, `m_wdata`  out  as d-side  downstream request fields.
- `m_ok`  in  1  downstream completion.
- `m_rdata`  in  DATA_W  downstream read data.

## Operation
- FSM states: `IDLE`, `BUSY_I`, `BUSY_D`.
- `IDLE`: when no request is pending, stay in `IDLE`.
  - When only one of `i_req`/`d_req` is high, grant that requester.
  - When both are high, grant per the priority rule (see Configuration).
  - On grant, latch the request fields into a request register and move to `BUSY_I` or `BUSY_D`.
- Fetch grant latches:
  - `m_addr = i_addr`, `m_size = MSIZE4`, `m_write = 0`, `m_strobe = 0`, `m_wdata = 0`.
- `BUSY_*`:
  - `m_valid = 1` and all `m_*` fields are driven from the latched register. They are stable for the whole transaction, independent of requester inputs.
  - On `m_ok`, assert the granted requester's `*_ok` in the same cycle and return to `IDLE`.
- Read data:
  - `d_rdata = m_rdata`, passed through combinationally.
  - `i_data = m_rdata[63:32]` if latched `addr[2]` is 1, else `m_rdata[31:0]`.
  - Both data outputs are valid only while their `*_ok` is high.
- Fetch drop (flush):
  - If `i_req` falls while in `BUSY_I`, set a `drop` flag.
  - The downstream transaction still completes. On `m_ok` with `drop` set, `i_ok` stays 0.
  - `drop` clears on the return to `IDLE`.
  - `d_req` is never dropped; behaviour is undefined if it falls while in `BUSY_D`.
- `last_d` register: set to 1 on a data grant and 0 on a fetch grant. It is used only in round-robin mode.
- The ungranted requester's `*_ok` is always 0.

## Timing
- Reset (`reset == 0` at an edge): state `IDLE`, `drop = 0`, `last_d = 0`, request register cleared.
- Output values while `IDLE` or in reset: `m_valid = 0`, all `m_*` fields 0, `i_ok = d_ok = 0`, `i_data = 0`, `d_rdata = 0`.
- Request latency: request sampled high in `IDLE` at cycle 0 gives `m_valid = 1` at cycle 1.
- Completion: `m_ok` at cycle k gives `*_ok` at cycle k, `IDLE` at k+1. The earliest next `m_valid` is k+2.
- Single-cycle memory (`m_ok` in the first `m_valid` cycle) is legal.
- `m_ok` while `IDLE` is ignored.
- Reset mid-transaction aborts it: `m_valid` drops at the next cycle and no `*_ok` is issued. The memory side must tolerate this.
- `i_req` re-asserted after a drop is arbitrated as a new request once the arbiter is back in `IDLE`.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin priority. When both request in `IDLE`:
  - `last_d == 1` grants fetch.
  - `last_d == 0` grants data.
- `MEM_ARB_RR_EN` undefined: fixed priority, data always wins. `last_d` is not implemented.

## Test plan
- Lone fetch:
  - Stimulus: `i_req = 1`, `i_addr = 0x8000_0004`, memory returns `m_ok` 3 cycles after `m_valid` with `m_rdata = 0x1111_2222_3333_4444`.
  - Required: `m_addr = 0x8000_0004`, `m_size = MSIZE4`, `m_write = 0`; `i_ok` pulses once with `i_data = 0x1111_2222`.
- Lone store:
  - Stimulus: `d_req = 1`, `d_write = 1`, `d_addr = 0x100`, `d_strobe = 0x0F`, `d_wdata = 0xDEAD_BEEF`.
  - Required: the `m_*` fields match the inputs and stay stable even if the d-inputs are perturbed mid-transaction; `d_ok` pulses once.
- Simultaneous requests, repeated 3 times:
  - With the macro defined: grant order D, I, D, I, D, I.
  - Without the macro: D is granted whenever both requests are high.
- Fetch flush:
  - Stimulus: `i_req` drops 1 cycle after `m_valid` rises.
  - Required: the transaction completes, `i_ok` stays 0, and the next `d_req` is granted at `IDLE`+1.
- Zero-wait memory:
  - Stimulus: `m_ok` tied high with back-to-back `d_req`.
  - Required: `d_ok` on every other cycle, `m_valid` pattern 1,0,1,0.
- Reset in `BUSY_D`:
  - Stimulus: `reset = 0` for 1 cycle mid-transaction.
  - Required: next cycle `m_valid = 0`, `d_ok` never pulses, state `IDLE`.
